// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - iterative shift-add multiplier (MUL/MLA/UMULL/SMULL) for the execute stage
// Sign-magnitude datapath: operands are made positive on capture and the product is negated in FIN.
module mult_unit #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             flush,
   input  logic [1:0]       op,
   input  logic             s,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] acc,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic [1:0]       flags_nz,
   output logic [1:0]       flag_w
);

   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);
   localparam int PW = 2 * WIDTH;
   localparam int SW = WIDTH + BITS_PER_CYCLE;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_MLA   = 2'b01;
   localparam logic [1:0] OP_SMULL = 2'b11;

   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
   localparam logic [PW-1:0]    ONE_P = PW'(1);
   localparam logic [CW-1:0]    CNT_N = CW'(N);
   localparam logic [CW-1:0]    CNT_1 = CW'(1);

   if ((WIDTH % 2) != 0 || WIDTH < 4 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
      $error("mult_unit: WIDTH must be even, >= 4 and a multiple of BITS_PER_CYCLE");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [1:0]       op_q, op_d;
   logic             s_q, s_d;
   logic             sign_q, sign_d;
   logic [WIDTH-1:0] res_lo_q, res_lo_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d;
   logic [1:0]       nz_q, nz_d;

   logic             is_signed;
   logic             capture;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [SW-1:0]    mcand_ext, partial, step_sum;
   logic [PW-1:0]    prod_step;
   logic [PW-1:0]    prod_fin;
   logic [WIDTH-1:0] fin_lo, fin_hi;
   logic [1:0]       fin_nz;

   // Magnitudes are taken only for SMULL; |most-negative| fits as an unsigned WIDTH-bit value.
   assign is_signed = (op == OP_SMULL);
   assign a_abs     = (is_signed && a[WIDTH-1]) ? (~a + ONE_W) : a;
   assign b_abs     = (is_signed && b[WIDTH-1]) ? (~b + ONE_W) : b;
   assign capture   = start && !flush && (state_q == S_IDLE || state_q == S_DONE);

   assign mcand_ext = {{BITS_PER_CYCLE{1'b0}}, mcand_q};

   always_comb begin
      partial = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (prod_q[i]) begin
            partial = partial + (mcand_ext << i);
         end
      end
   end

   // The multiplier sits in the low half and is shifted out as the product grows into the top.
   assign step_sum = {{BITS_PER_CYCLE{1'b0}}, prod_q[PW-1:WIDTH]} + partial;

   if (BITS_PER_CYCLE == WIDTH) begin : g_step_full
      assign prod_step = step_sum;
   end else begin : g_step_part
      assign prod_step = {step_sum, prod_q[WIDTH-1:BITS_PER_CYCLE]};
   end

   always_comb begin
      prod_fin = sign_q ? (~prod_q + ONE_P) : prod_q;
      fin_lo   = prod_fin[WIDTH-1:0] + ((op_q == OP_MLA) ? acc_q : '0);
      fin_hi   = op_q[1] ? prod_fin[PW-1:WIDTH] : '0;
      if (op_q[1]) begin
         fin_nz = {fin_hi[WIDTH-1], ({fin_hi, fin_lo} == '0)};
      end else begin
         fin_nz = {fin_lo[WIDTH-1], (fin_lo == '0)};
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      acc_d    = acc_q;
      op_d     = op_q;
      s_d      = s_q;
      sign_d   = sign_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      nz_d     = nz_q;
      busy     = 1'b0;
      done     = 1'b0;
      flag_w   = 2'b00;

      if (capture) begin
         mcand_d = a_abs;
         prod_d  = {{WIDTH{1'b0}}, b_abs};
         acc_d   = acc;
         op_d    = op;
         s_d     = s;
         sign_d  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
         cnt_d   = CNT_N;
      end

      case (state_q)
         S_IDLE: begin
            if (capture) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               prod_d = prod_step;
               cnt_d  = cnt_q - CNT_1;
               if (cnt_q == CNT_1) begin
                  state_d = S_FIN;
               end
            end
         end
         S_FIN: begin
            busy = 1'b1;
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               res_lo_d = fin_lo;
               res_hi_d = fin_hi;
               nz_d     = fin_nz;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            flag_w = s_q ? 2'b01 : 2'b00;
            // Back-to-back issue keeps the pipeline stalled through the DONE cycle.
            if (capture) begin
               busy    = 1'b1;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         prod_q   <= '0;
         acc_q    <= '0;
         op_q     <= OP_MUL;
         s_q      <= 1'b0;
         sign_q   <= 1'b0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         nz_q     <= 2'b00;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         acc_q    <= acc_d;
         op_q     <= op_d;
         s_q      <= s_d;
         sign_q   <= sign_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         nz_q     <= nz_d;
      end
   end

   assign result_lo = res_lo_q;
   assign result_hi = res_hi_q;
   assign flags_nz  = nz_q;

endmodule

// File: tb/tb_mult_unit.sv
// tb/tb_mult_unit.sv - self-checking bench for mult_unit (32/1, 16/4, 16/8 configurations)
module tb_mult_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, start, flush, s;
   logic [1:0]  op;
   logic [31:0] a, b, acc;
   logic        busy, done;
   logic [31:0] result_lo, result_hi;
   logic [1:0]  flags_nz, flag_w;

   logic        start16, flush16, s16;
   logic [1:0]  op16;
   logic [15:0] a16, b16, acc16;
   logic        busy_4, done_4, busy_8, done_8;
   logic [15:0] lo_4, hi_4, lo_8, hi_8;
   logic [1:0]  nz_4, fw_4, nz_8, fw_8;

   int tests = 0;
   int fails = 0;

   mult_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_m32 (
      .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .op(op), .s(s),
      .a(a), .b(b), .acc(acc), .busy(busy), .done(done), .result_lo(result_lo),
      .result_hi(result_hi), .flags_nz(flags_nz), .flag_w(flag_w));

   mult_unit #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_m16_4 (
      .clk(clk), .reset_n(reset_n), .start(start16), .flush(flush16), .op(op16), .s(s16),
      .a(a16), .b(b16), .acc(acc16), .busy(busy_4), .done(done_4), .result_lo(lo_4),
      .result_hi(hi_4), .flags_nz(nz_4), .flag_w(fw_4));

   mult_unit #(.WIDTH(16), .BITS_PER_CYCLE(8)) u_m16_8 (
      .clk(clk), .reset_n(reset_n), .start(start16), .flush(flush16), .op(op16), .s(s16),
      .a(a16), .b(b16), .acc(acc16), .busy(busy_8), .done(done_8), .result_lo(lo_8),
      .result_hi(hi_8), .flags_nz(nz_8), .flag_w(fw_8));

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic        s;
      logic [31:0] a, b, acc;
      logic [31:0] lo, hi;
      logic [1:0]  nz, fw;
   } vec32_t;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [15:0] a, b, acc;
      logic [15:0] lo, hi;
      logic [1:0]  nz;
   } vec16_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic straight from the ISA definition of each op.
   function automatic logic [65:0] model32(input logic [1:0] o, input logic [31:0] x,
                                           input logic [31:0] y, input logic [31:0] z);
      logic [63:0] p;
      logic [31:0] t;
      logic [1:0]  nz;
      longint      sx, sy;
      case (o)
         2'b00: begin t = x * y;     p = {32'h0, t}; end
         2'b01: begin t = x * y + z; p = {32'h0, t}; end
         2'b10: p = {32'h0, x} * {32'h0, y};
         default: begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            p  = 64'(sx * sy);
         end
      endcase
      if (o[1]) nz = {p[63], (p == 64'h0)};
      else      nz = {p[31], (p[31:0] == 32'h0)};
      return {nz, p};
   endfunction

   task automatic launch32(input logic [1:0] o, input logic sv, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] z);
      @(negedge clk);
      op = o; s = sv; a = x; b = y; acc = z; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done32(output int edges);
      edges = 0;
      while (!done && edges < 200) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
   endtask

   task automatic run_check32(input string name, input logic [1:0] o, input logic sv,
                              input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                              input logic [31:0] elo, input logic [31:0] ehi,
                              input logic [1:0] enz, input logic [1:0] efw);
      int edges;
      launch32(o, sv, x, y, z);
      chk({name, " busy_run"}, 64'(busy), 64'(1'b1));
      wait_done32(edges);
      chk({name, " latency"}, 64'(edges), 64'(33));
      chk({name, " lo"}, 64'(result_lo), 64'(elo));
      chk({name, " hi"}, 64'(result_hi), 64'(ehi));
      chk({name, " nz"}, 64'(flags_nz), 64'(enz));
      chk({name, " flag_w"}, 64'(flag_w), 64'(efw));
      chk({name, " busy_done"}, 64'(busy), 64'(1'b0));
      @(negedge clk);
      chk({name, " done_pulse"}, 64'(done), 64'(1'b0));
      chk({name, " flag_w_clr"}, 64'(flag_w), 64'(2'b00));
      chk({name, " lo_hold"}, 64'(result_lo), 64'(elo));
   endtask

   task automatic run16(input vec16_t v);
      int e4, e8;
      @(negedge clk);
      op16 = v.op; a16 = v.a; b16 = v.b; acc16 = v.acc; s16 = 1'b0; start16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start16 = 1'b0;
      e4 = -1;
      e8 = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done_4 && e4 < 0) e4 = k;
         if (done_8 && e8 < 0) e8 = k;
      end
      chk({v.name, " lat_bpc4"}, 64'(e4), 64'(5));
      chk({v.name, " lat_bpc8"}, 64'(e8), 64'(3));
      chk({v.name, " lo_bpc4"}, 64'(lo_4), 64'(v.lo));
      chk({v.name, " hi_bpc4"}, 64'(hi_4), 64'(v.hi));
      chk({v.name, " nz_bpc4"}, 64'(nz_4), 64'(v.nz));
      chk({v.name, " lo_bpc8"}, 64'(lo_8), 64'(v.lo));
      chk({v.name, " hi_bpc8"}, 64'(hi_8), 64'(v.hi));
      chk({v.name, " nz_bpc8"}, 64'(nz_8), 64'(v.nz));
   endtask

   initial begin
      vec32_t      t32[$];
      vec16_t      t16[$];
      logic [65:0] m;
      logic [31:0] ra, rb, rz;
      logic [1:0]  ro;
      logic        rs;
      int          edges, dones;

      t32.push_back('{"mul_7x6",       2'b00, 1'b0, 32'h7,        32'h6,        32'h0, 32'h0000002A, 32'h0,        2'b00, 2'b00});
      t32.push_back('{"mla_wrap",      2'b01, 1'b1, 32'hFFFFFFFF, 32'h2,        32'h3, 32'h00000001, 32'h0,        2'b00, 2'b01});
      t32.push_back('{"mul_zero",      2'b00, 1'b1, 32'h0,        32'h5,        32'h0, 32'h00000000, 32'h0,        2'b01, 2'b01});
      t32.push_back('{"umull_max",     2'b10, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h00000001, 32'hFFFFFFFE, 2'b10, 2'b00});
      t32.push_back('{"smull_m2x3",    2'b11, 1'b1, 32'hFFFFFFFE, 32'h3,        32'h0, 32'hFFFFFFFA, 32'hFFFFFFFF, 2'b10, 2'b01});
      t32.push_back('{"smull_minsq",   2'b11, 1'b0, 32'h80000000, 32'h80000000, 32'h0, 32'h00000000, 32'h40000000, 2'b00, 2'b00});
      t32.push_back('{"smull_m1xmin",  2'b11, 1'b0, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h80000000, 32'h00000000, 2'b00, 2'b00});
      t32.push_back('{"umull_zero",    2'b10, 1'b1, 32'h0,        32'h0,        32'h0, 32'h00000000, 32'h00000000, 2'b01, 2'b01});
      t32.push_back('{"mla_hi_forced", 2'b01, 1'b0, 32'h00010000, 32'h00010000, 32'h9, 32'h00000009, 32'h0,        2'b00, 2'b00});

      t16.push_back('{"w16_umull",  2'b10, 16'hFFFF, 16'h0003, 16'h0, 16'hFFFD, 16'h0002, 2'b00});
      t16.push_back('{"w16_smull",  2'b11, 16'h8000, 16'h8000, 16'h0, 16'h0000, 16'h4000, 2'b00});
      t16.push_back('{"w16_mla",    2'b01, 16'h0100, 16'h0100, 16'h5, 16'h0005, 16'h0000, 2'b00});
      t16.push_back('{"w16_smullneg", 2'b11, 16'hFFFE, 16'h0003, 16'h0, 16'hFFFA, 16'hFFFF, 2'b10});

      reset_n = 1'b0; start = 1'b0; flush = 1'b0; s = 1'b0; op = 2'b00;
      a = '0; b = '0; acc = '0;
      start16 = 1'b0; flush16 = 1'b0; s16 = 1'b0; op16 = 2'b00; a16 = '0; b16 = '0; acc16 = '0;
      repeat (2) @(negedge clk);
      chk("rst busy", 64'(busy), 64'(1'b0));
      chk("rst done", 64'(done), 64'(1'b0));
      chk("rst lo", 64'(result_lo), 64'(0));
      chk("rst hi", 64'(result_hi), 64'(0));
      chk("rst nz", 64'(flags_nz), 64'(0));
      chk("rst flag_w", 64'(flag_w), 64'(0));
      reset_n = 1'b1;
      @(negedge clk);

      foreach (t32[i]) begin
         run_check32(t32[i].name, t32[i].op, t32[i].s, t32[i].a, t32[i].b, t32[i].acc,
                     t32[i].lo, t32[i].hi, t32[i].nz, t32[i].fw);
      end

      // start pulsed while RUN: ignored, exactly one done with the first result
      launch32(2'b00, 1'b0, 32'd7, 32'd6, 32'd0);
      repeat (5) @(negedge clk);
      a = 32'd99; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) dones++;
      end
      chk("run_start dones", 64'(dones), 64'(1));
      chk("run_start lo", 64'(result_lo), 64'(32'h2A));

      // back-to-back: start held during DONE
      launch32(2'b10, 1'b0, 32'd1000, 32'd1000, 32'd0);
      wait_done32(edges);
      chk("b2b first lo", 64'(result_lo), 64'(32'd1000000));
      op = 2'b11; s = 1'b1; a = 32'hFFFFFFF0; b = 32'd5; acc = 32'd0; start = 1'b1;
      #1;
      chk("b2b busy_done", 64'(busy), 64'(1'b1));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done32(edges);
      m = model32(2'b11, 32'hFFFFFFF0, 32'd5, 32'd0);
      chk("b2b latency", 64'(edges), 64'(33));
      chk("b2b lo", 64'(result_lo), 64'(m[31:0]));
      chk("b2b hi", 64'(result_hi), 64'(m[63:32]));
      chk("b2b nz", 64'(flags_nz), 64'(m[65:64]));
      chk("b2b flag_w", 64'(flag_w), 64'(2'b01));
      @(negedge clk);

      // flush in RUN: busy drops next cycle, no done, outputs hold
      launch32(2'b00, 1'b0, 32'd3, 32'd3, 32'd0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush busy", 64'(busy), 64'(1'b0));
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) dones++;
      end
      chk("flush dones", 64'(dones), 64'(0));
      chk("flush lo_hold", 64'(result_lo), 64'(m[31:0]));

      // flush together with start in IDLE: nothing captured
      @(negedge clk);
      op = 2'b00; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("flush_start busy", 64'(busy), 64'(1'b0));
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) dones++;
      end
      chk("flush_start dones", 64'(dones), 64'(0));

      // asynchronous reset mid-RUN
      launch32(2'b10, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);
      repeat (5) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst busy", 64'(busy), 64'(1'b0));
      chk("arst done", 64'(done), 64'(1'b0));
      chk("arst lo", 64'(result_lo), 64'(0));
      chk("arst hi", 64'(result_hi), 64'(0));
      chk("arst nz", 64'(flags_nz), 64'(0));
      chk("arst flag_w", 64'(flag_w), 64'(0));
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // randomized ops with corner-biased operands
      for (int i = 0; i < 30; i++) begin
         ro = 2'($urandom_range(0, 3));
         rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: ra = 32'h80000000;
            1: ra = 32'hFFFFFFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0: rb = 32'h0;
            1: rb = 32'h80000000;
            default: rb = $urandom;
         endcase
         rz = $urandom;
         m = model32(ro, ra, rb, rz);
         run_check32($sformatf("rnd%0d", i), ro, rs, ra, rb, rz,
                     m[31:0], m[63:32], m[65:64], rs ? 2'b01 : 2'b00);
      end

      foreach (t16[i]) run16(t16[i]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative multiplier for the execute stage. Handles the multiply class that the ALU decoder flags via `mult`.
- Supports MUL, MLA, UMULL and SMULL, with configurable operand width and bits retired per cycle.
- Uses a start/busy/done handshake and produces NZ flags plus a flag_w mask for the flags register.
- Replaces the single-cycle combinational multiply path.

Parameters:
WIDTH, 32, operand width in bits; must be even and at least 4.
BITS_PER_CYCLE, 1, multiplier bits consumed per RUN cycle; must divide WIDTH exactly. 1, 2, 4 and 8 must be supported.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request a new operation; sampled only in IDLE or DONE
flush  input  1  synchronous abort (e.g. branch taken); wins over start
op  input  2  00 MUL, 01 MLA, 10 UMULL, 11 SMULL
s  input  1  set-flags bit of the instruction
a  input  WIDTH  multiplicand (Rm)
b  input  WIDTH  multiplier (Rs)
acc  input  WIDTH  accumuland (Rn); used for MLA only
busy  output  1  operation in progress; stall request to the pipeline
done  output  1  one-cycle pulse; results valid in this cycle
result_lo  output  WIDTH  low word of the result
result_hi  output  WIDTH  high word for UMULL/SMULL; 0 for MUL/MLA
flags_nz  output  2  {N,Z} of the result; valid while done is high
flag_w  output  2  01 when done is high and captured s=1; 00 otherwise

Behaviour:
- Clock and reset: one clock, `clk`; reset is asynchronous, active-low, on `reset_n`.
- Reset state: FSM goes to IDLE. busy, done, result_lo, result_hi, flags_nz and flag_w are all 0. Internal accumulator, counter and captured operands are all 0.
- Reset asserted mid-operation aborts immediately. No done is produced.
- States: IDLE, RUN, FIN, DONE.
- IDLE: start=1 captures a, b, acc, op and s, then goes to RUN.
  - Signed op (SMULL): store |a|, |b| and sign = a[W-1]^b[W-1].
  - Unsigned ops: sign = 0.
  - Counter is loaded with N = WIDTH/BITS_PER_CYCLE.
- RUN: shift-add of BITS_PER_CYCLE multiplier bits per cycle into a 2*WIDTH product register; the counter decrements each cycle. When the counter reaches 1, go to FIN.
- FIN: post-processing in one cycle.
  - Negate the 2*WIDTH product if sign=1.
  - MLA: add acc to the low word, modulo 2^WIDTH.
  - MUL/MLA: force the high word to 0.
  - Compute flags:
    - MUL/MLA: N = lo[W-1], Z = (lo==0).
    - UMULL/SMULL: N = hi[W-1], Z = ({hi,lo}==0).
  - Go to DONE.
- DONE: done=1 for exactly one cycle; flag_w=01 if captured s=1.
  - start=1 here captures a new operation (back-to-back) and goes to RUN. Otherwise go to IDLE.
- Latency: start is sampled on edge 0. busy is high from edge 0 until edge N+2. done is high between edge N+1 and edge N+2. Total latency is N+2 cycles.
- busy is low in IDLE and in a DONE cycle without start.
- Output hold: result_lo, result_hi and flags_nz stay valid from DONE until the next start is captured. flag_w returns to 00 after DONE.
- start in RUN or FIN is ignored; the operation in flight is unaffected.
- flush=1 in RUN or FIN: go to IDLE on the next edge, drop busy, no done. Output registers keep their previous values.
- flush=1 together with start in IDLE or DONE: flush wins and nothing is captured.
- Edge cases:
  - Most-negative operand: |0x80000000| = 0x80000000 unsigned; the result must still be correct.
  - Zero operands run the full latency; there is no early termination.

Test Plan:
- MUL, WIDTH=32, BPC=1: a=7, b=6, s=0 → done exactly 34 cycles after start, result_lo=0x0000002A, result_hi=0, flag_w=00.
- MLA, s=1: a=0xFFFFFFFF, b=2, acc=3 → result_lo=0x00000001, N=0, Z=0, flag_w=01. Then MUL 0×5, s=1 → result_lo=0, Z=1.
- UMULL: 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- SMULL: −2×3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA, N=1. Also 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- Handshake:
  - start pulsed again in RUN → ignored, single done.
  - start held during the DONE cycle → second result 34 cycles later.
  - flush at RUN cycle 10 → busy drops next cycle, no done.
  - reset_n low mid-RUN → all outputs 0 asynchronously.
- Parametrisation: WIDTH=16, BPC=4, UMULL 0xFFFF×0x0003 → done after 6 cycles, hi=0x0002, lo=0xFFFD. Repeat with BPC=8 → done after 4 cycles.
